pmux_prog_loader: RTL

PMUX_PROG_LOADER -- requirements
Module: pmux_prog_loader

---
 rtl/pmux_prog_pkg.sv | 26 ++
 rtl/pmux_prog_phasegen.sv | 48 ++++
 rtl/pmux_prog_loader.sv | 109 ++++++++++
 3 files changed

// File: rtl/pmux_prog_pkg.sv
// Shared types and defaults for the pmux programming-chain loader.
// The state encoding is visible to the phase generator so it can time each segment.
package pmux_prog_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      SETUP,
      PH0,
      GAP0,
      PH1,
      GAP1,
      DONE
   } state_t;

   localparam int PULSE_CYC_DEF = 2;
   localparam int GAP_CYC_DEF   = 1;
   localparam int STEP_W_DEF    = 16;
   localparam int TMR_W         = 4;

   // Terminal value of the segment timer for a segment lasting cyc cycles.
   function automatic logic [TMR_W-1:0] last_count(input int cyc);
      return TMR_W'(cyc - 1);
   endfunction

endpackage

// File: rtl/pmux_prog_phasegen.sv
// Segment timer and registered, non-overlapping programming clocks.
// The segment order SETUP->PH0->GAP0->PH1->GAP1 is fixed, so each clock's next value follows from state and timer alone.
module pmux_prog_phasegen
   import pmux_prog_pkg::*;
#(
   parameter int PULSE_CYC = PULSE_CYC_DEF,
   parameter int GAP_CYC   = GAP_CYC_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] state,
   output logic       last,
   output logic       prog_clk0,
   output logic       prog_clk1
);

   localparam logic [TMR_W-1:0] PULSE_LAST = last_count(PULSE_CYC);
   localparam logic [TMR_W-1:0] GAP_LAST   = last_count(GAP_CYC);

   state_t           st;
   logic             in_pulse;
   logic             timed;
   logic [TMR_W-1:0] cnt;
   logic [TMR_W-1:0] cnt_end;

   assign st = state_t'(state);

   always_comb begin
      in_pulse = (st == PH0) || (st == PH1);
      timed    = in_pulse || (st == SETUP) || (st == GAP0) || (st == GAP1);
      cnt_end  = in_pulse ? PULSE_LAST : GAP_LAST;
      last     = timed && (cnt == cnt_end);
   end

   // The timer restarts at zero on every segment boundary and idles at zero in untimed states.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= '0;
         prog_clk0 <= 1'b0;
         prog_clk1 <= 1'b0;
      end else begin
         cnt       <= (timed && !last) ? cnt + TMR_W'(1) : '0;
         prog_clk0 <= ((st == SETUP) && last) || ((st == PH0) && !last);
         prog_clk1 <= ((st == GAP0)  && last) || ((st == PH1) && !last);
      end
   end

endmodule

// File: rtl/pmux_prog_loader.sv
// Serial bitstream loader for a two-phase pmux configuration chain.
// Bytes are fetched on demand and shifted out LSB first, one bit per clk0/clk1 pulse pair.
module pmux_prog_loader
   import pmux_prog_pkg::*;
#(
   parameter int PULSE_CYC = PULSE_CYC_DEF,
   parameter int GAP_CYC   = GAP_CYC_DEF,
   parameter int STEP_W    = STEP_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [STEP_W-1:0] num_steps,
   input  logic              cfg_valid,
   input  logic [7:0]        cfg_data,
   output logic              cfg_ready,
   output logic              prog_in,
   output logic              prog_clk0,
   output logic              prog_clk1,
   output logic              busy,
   output logic              done
);

   state_t            state;
   logic [7:0]        byte_r;
   logic [2:0]        bit_idx;
   logic [STEP_W-1:0] remaining;
   logic              last;

   pmux_prog_phasegen #(
      .PULSE_CYC (PULSE_CYC),
      .GAP_CYC   (GAP_CYC)
   ) u_phasegen (
      .clk       (clk),
      .rst       (rst),
      .state     (state),
      .last      (last),
      .prog_clk0 (prog_clk0),
      .prog_clk1 (prog_clk1)
   );

   // Outputs are set on the transition into the state they describe, so they line up with state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         bit_idx   <= '0;
         remaining <= '0;
         prog_in   <= 1'b0;
         cfg_ready <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  remaining <= num_steps;
                  bit_idx   <= '0;
                  busy      <= 1'b1;
                  if (num_steps == '0) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state     <= FETCH;
                     cfg_ready <= 1'b1;
                  end
               end
            end
            FETCH: begin
               if (cfg_valid && cfg_ready) begin
                  byte_r    <= cfg_data;
                  prog_in   <= cfg_data[bit_idx];
                  cfg_ready <= 1'b0;
                  state     <= SETUP;
               end
            end
            SETUP: if (last) state <= PH0;
            PH0:   if (last) state <= GAP0;
            GAP0:  if (last) state <= PH1;
            PH1:   if (last) state <= GAP1;
            GAP1: begin
               if (last) begin
                  remaining <= remaining - STEP_W'(1);
                  // Stopping on the step count drops any unused high bits of the final byte.
                  if (remaining == STEP_W'(1)) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else if (bit_idx == 3'd7) begin
                     bit_idx   <= '0;
                     cfg_ready <= 1'b1;
                     state     <= FETCH;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     prog_in <= byte_r[bit_idx + 3'd1];
                     state   <= SETUP;
                  end
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
